// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 instruction fields into 32-bit words, queues them
// in a small FIFO and streams them to instruction memory at consecutive byte
// addresses, starting from a base address loaded by prog_start.
module instr_encoder #(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [6:0]   opcode,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [2:0]   fn3,
    input  logic         fn7_5,
    input  logic         fn7_1,
    input  logic [11:0]  imm,
    input  logic [19:0]  imm_uj,
    input  logic         prog_start,
    input  logic [N-1:0] base_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    output logic         err_unsupported,
    output logic [15:0]  word_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_U     = 7'b0110111;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   fifo_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [15:0]    wcnt_q, wcnt_d;
    logic           err_q, err_d;

    logic [31:0]    enc;
    logic           supported;
    logic           full;
    logic           push;
    logic           enq;
    logic           pop;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    // Field packing per instruction format; unknown opcodes are flagged.
    always_comb begin
        enc       = 32'b0;
        supported = 1'b1;
        case (opcode)
            OP_R:          enc = {1'b0, fn7_5, 4'b0, fn7_1, rs2, rs1, fn3, rd, opcode};
            OP_I, OP_LOAD: enc = {imm, rs1, fn3, rd, opcode};
            OP_STORE:      enc = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
            OP_B:          enc = {imm[11], imm[9:4], rs2, rs1, fn3, imm[3:0], imm[10], opcode};
            OP_J:          enc = {imm_uj[19], imm_uj[9:0], imm_uj[10], imm_uj[18:11], rd, opcode};
            OP_U:          enc = {imm_uj, rd, opcode};
            default:       supported = 1'b0;
        endcase
    end

    // in_ready depends only on occupancy and reset, never on mem_ack, so the
    // memory side cannot form a combinational loop back to the producer.
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full && !rst;

    // prog_start overrides both a concurrent push and a concurrent ack.
    assign push = in_valid && in_ready && !prog_start;
    assign enq  = push && supported;
    assign pop  = (state_q == WRITE) && mem_ack && !prog_start;

    // Next-state for FIFO bookkeeping, address/count and the write FSM.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        err_d    = push && !supported;
        if (prog_start) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            addr_d   = base_addr;
            wcnt_d   = 16'd0;
            err_d    = 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
                addr_d   = addr_q + N'(4);
                wcnt_d   = wcnt_q + 16'd1;
            end
            case ({enq, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (count_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and address state, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            wcnt_q   <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr_q] <= N'(enc);
        end
    end

    assign mem_we          = (state_q == WRITE);
    assign mem_addr        = addr_q;
    assign mem_wdata       = mem_we ? fifo_q[rd_ptr_q] : '0;
    assign word_count      = wcnt_q;
    assign err_unsupported = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, backpressure, unsupported
// opcodes, prog_start flush, address wrap and asynchronous reset mid-write.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  fn3;
    logic        fn7_5, fn7_1;
    logic [11:0] imm;
    logic [19:0] imm_uj;
    logic        prog_start;
    logic [31:0] base_addr;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        err_unsupported;
    logic [15:0] word_count;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fn3;
        logic        f5;
        logic        f1;
        logic [11:0] imm;
        logic [19:0] uj;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [12];

    instr_encoder #(.N(32), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opcode          (opcode),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .fn3             (fn3),
        .fn7_5           (fn7_5),
        .fn7_1           (fn7_1),
        .imm             (imm),
        .imm_uj          (imm_uj),
        .prog_start      (prog_start),
        .base_addr       (base_addr),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .err_unsupported (err_unsupported),
        .word_count      (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx);
        opcode = vec[idx].op;
        rd     = vec[idx].rd;
        rs1    = vec[idx].rs1;
        rs2    = vec[idx].rs2;
        fn3    = vec[idx].fn3;
        fn7_5  = vec[idx].f5;
        fn7_1  = vec[idx].f1;
        imm    = vec[idx].imm;
        imm_uj = vec[idx].uj;
    endtask

    task automatic pstart(input logic [31:0] b);
        prog_start = 1'b1;
        base_addr  = b;
        tick();
        prog_start = 1'b0;
    endtask

    // Push one tuple, wait for its write, check word and address, then ack.
    task automatic write_one(input int idx, input logic [31:0] exp_addr);
        int n;
        drive(idx);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("v%0d_we", idx), 32'(mem_we), 32'd1);
        check($sformatf("v%0d_wdata", idx), mem_wdata, vec[idx].exp);
        check($sformatf("v%0d_addr", idx), mem_addr, exp_addr);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        int k;
        int w;
        int c;
        logic acc;
        logic [15:0] wc_saved;

        n_chk  = 0;
        n_fail = 0;

        vec[0]  = '{7'b0010011, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 12'h005, 20'h00000, 32'h00500093};
        vec[1]  = '{7'b0110011, 5'd3,  5'd1,  5'd2,  3'd0, 1'b1, 1'b0, 12'h000, 20'h00000, 32'h402081B3};
        vec[2]  = '{7'b0100011, 5'd0,  5'd1,  5'd2,  3'd2, 1'b0, 1'b0, 12'h008, 20'h00000, 32'h0020A423};
        vec[3]  = '{7'b1101111, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 12'h000, 20'h00004, 32'h008000EF};
        vec[4]  = '{7'b0110111, 5'd5,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 12'h000, 20'h12345, 32'h123452B7};
        vec[5]  = '{7'b0000011, 5'd2,  5'd3,  5'd0,  3'd2, 1'b0, 1'b0, 12'hFFC, 20'h00000, 32'hFFC1A103};
        vec[6]  = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd1, 1'b0, 1'b0, 12'h801, 20'h00000, 32'h80001163};
        vec[7]  = '{7'b1100011, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 12'h410, 20'h00000, 32'h020000E3};
        vec[8]  = '{7'b0110011, 5'd10, 5'd11, 5'd12, 3'd0, 1'b0, 1'b1, 12'h000, 20'h00000, 32'h02C58533};
        vec[9]  = '{7'b0010011, 5'd1,  5'd0,  5'd31, 3'd0, 1'b1, 1'b1, 12'h005, 20'hFFFFF, 32'h00500093};
        vec[10] = '{7'b1101111, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 1'b0, 12'h000, 20'h80C00, 32'h8010106F};
        vec[11] = '{7'b0100011, 5'd31, 5'd2,  5'd3,  3'd0, 1'b0, 1'b0, 12'hFFF, 20'h00000, 32'hFE310FA3};

        rst        = 1'b0;
        in_valid   = 1'b0;
        prog_start = 1'b0;
        base_addr  = 32'h0;
        mem_ack    = 1'b0;
        drive(0);

        // Reset state, observed while rst is held
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wcnt", 32'(word_count), 32'd0);
        check("rst_err", 32'(err_unsupported), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // First word at a programmed base
        pstart(32'h100);
        write_one(0, 32'h100);
        check("first_wcnt", 32'(word_count), 32'd1);
        check("first_addr_next", mem_addr, 32'h104);

        // Remaining encodings at consecutive addresses
        for (int i = 1; i < 12; i++) begin
            write_one(i, 32'h104 + 32'(4 * (i - 1)));
        end
        check("table_wcnt", 32'(word_count), 32'd12);

        // Backpressure: no acks, three tuples offered
        pstart(32'h300);
        k = 0;
        for (int cy = 0; cy < 6; cy++) begin
            if (k < 3) begin
                drive(k);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
        end
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_we", 32'(mem_we), 32'd1);
        check("bp_addr", mem_addr, 32'h300);
        check("bp_wdata", mem_wdata, vec[0].exp);
        tick();
        tick();
        tick();
        check("bp_addr_hold", mem_addr, 32'h300);
        check("bp_wdata_hold", mem_wdata, vec[0].exp);
        check("bp_ready_hold", 32'(in_ready), 32'd0);
        w = 0;
        c = 0;
        while (w < 3 && c < 40) begin
            if (k < 3) begin
                drive(k);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            mem_ack = mem_we;
            if (mem_we) begin
                check($sformatf("bp_drain%0d_wdata", w), mem_wdata, vec[w].exp);
                check($sformatf("bp_drain%0d_addr", w), mem_addr, 32'h300 + 32'(4 * w));
                w++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            c++;
        end
        mem_ack  = 1'b0;
        in_valid = 1'b0;
        check("bp_drain_count", 32'(w), 32'd3);
        check("bp_wcnt", 32'(word_count), 32'd3);

        // Unsupported opcode: one-cycle error pulse, nothing written
        wc_saved = word_count;
        check("unsup_err_before", 32'(err_unsupported), 32'd0);
        drive(0);
        opcode   = 7'b1110011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("unsup_err_pulse", 32'(err_unsupported), 32'd1);
        check("unsup_we0", 32'(mem_we), 32'd0);
        tick();
        check("unsup_err_clear", 32'(err_unsupported), 32'd0);
        tick();
        tick();
        check("unsup_we1", 32'(mem_we), 32'd0);
        check("unsup_wcnt", 32'(word_count), 32'(wc_saved));

        // prog_start flushes two queued words, ignoring concurrent push and ack
        for (int i = 0; i < 2; i++) begin
            drive(i + 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("flush_we_before", 32'(mem_we), 32'd1);
        drive(3);
        in_valid   = 1'b1;
        mem_ack    = 1'b1;
        prog_start = 1'b1;
        base_addr  = 32'h200;
        tick();
        prog_start = 1'b0;
        in_valid   = 1'b0;
        mem_ack    = 1'b0;
        check("flush_we", 32'(mem_we), 32'd0);
        check("flush_wcnt", 32'(word_count), 32'd0);
        check("flush_addr", mem_addr, 32'h200);
        check("flush_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        tick();
        check("flush_we_stays", 32'(mem_we), 32'd0);
        write_one(4, 32'h200);

        // Address wraps modulo 2^32
        pstart(32'hFFFF_FFFC);
        write_one(5, 32'hFFFF_FFFC);
        write_one(6, 32'h0000_0000);
        check("wrap_addr_next", mem_addr, 32'h4);

        // Asynchronous reset in the middle of a pending write
        drive(7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        c = 0;
        while (!mem_we && c < 20) begin
            tick();
            c++;
        end
        check("mid_we_before", 32'(mem_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_wdata", mem_wdata, 32'h0);
        check("mid_rst_wcnt", 32'(word_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_err", 32'(err_unsupported), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_post_ready", 32'(in_ready), 32'd1);
        check("mid_post_we", 32'(mem_we), 32'd0);
        write_one(8, 32'h0);
        check("mid_post_wcnt", 32'(word_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: N, default 32, instruction word and memory address width.
REQ-002 Parameter: DEPTH, default 2, number of entries in the encoded-word FIFO.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  a field tuple is presented.
REQ-006 in_ready  output  1  the block accepts the tuple this cycle.
REQ-007 opcode  input  7  instruction class.
REQ-008 rd, rs1, rs2  input  5 each  register indices.
REQ-009 fn3  input  3  funct3 field.
REQ-010 fn7_5, fn7_1  input  1 each  funct7 bit 5 and funct7 bit 0.
REQ-011 imm  input  12  12-bit immediate, in the I, S or B field order.
REQ-012 imm_uj  input  20  20-bit immediate, in the J or U field order.
REQ-013 prog_start  input  1  one-cycle pulse that restarts loading.
REQ-014 base_addr  input  N  load address captured on prog_start.
REQ-015 mem_we  output  1  write request to instruction memory.
REQ-016 mem_addr  output  N  byte address of the write.
REQ-017 mem_wdata  output  N  encoded instruction word.
REQ-018 mem_ack  input  1  memory accepted the write this cycle.
REQ-019 err_unsupported  output  1  one-cycle pulse for an unsupported opcode.
REQ-020 word_count  output  16  number of words written since the last prog_start or reset.

Function
REQ-021 A transfer (push) SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high only when the FIFO is not full and rst is low, with no combinational path from mem_ack.
REQ-022 Encoding SHALL be combinational on the pushed fields, and the encoded word SHALL be written into the FIFO on the push edge:
  - R, opcode 0110011: {1'b0, fn7_5, 4'b0, fn7_1, rs2, rs1, fn3, rd, opcode}.
  - I, opcode 0010011, and Load, opcode 0000011: {imm, rs1, fn3, rd, opcode}.
  - Store, opcode 0100011: {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode}.
  - B, opcode 1100011: {imm[11], imm[9:4], rs2, rs1, fn3, imm[3:0], imm[10], opcode}.
  - J, opcode 1101111: {imm_uj[19], imm_uj[9:0], imm_uj[10], imm_uj[18:11], rd, opcode}.
  - U, opcode 0110111: {imm_uj, rd, opcode}.
  - Fields that an opcode does not use SHALL be ignored.
REQ-023 A push with any other opcode SHALL be consumed without enqueuing, and err_unsupported SHALL be high for exactly the following cycle.
REQ-024 The write-side FSM SHALL have two states:
  - IDLE: mem_we=0; go to WRITE when the FIFO is non-empty.
  - WRITE: mem_we=1; mem_addr and mem_wdata (FIFO head) held stable until mem_ack.
REQ-025 On mem_ack in WRITE: pop the FIFO, mem_addr += 4 (wrapping modulo 2^N), word_count += 1 (wrapping at 16 bits).
  - Stay in WRITE if another entry remains, otherwise return to IDLE.
  - mem_ack while mem_we is low SHALL be ignored.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and the pushed word SHALL go behind the head.
REQ-027 prog_start SHALL, on that edge:
  - set mem_addr to base_addr and word_count to 0;
  - flush the FIFO and return the FSM to IDLE;
  - ignore any concurrent push or mem_ack.
REQ-028 The FIFO SHALL preserve order; a FIFO that is full SHALL block pushes; a FIFO that is empty SHALL hold mem_we low.

Reset
REQ-029 While rst is high, the block SHALL immediately (asynchronously) drive:
  - FSM=IDLE, FIFO empty, in_ready=0, mem_we=0;
  - mem_addr=0, mem_wdata=0, word_count=0, err_unsupported=0.
REQ-030 Reset asserted mid-WRITE SHALL drop the pending word without completing it; after release, in_ready SHALL go to 1 on the first cycle.

Verification
REQ-031 prog_start with base_addr=0x100, then push an I-type tuple (rd=1, rs1=0, fn3=0, imm=5), mem_ack immediate -> mem_wdata=0x00500093 at mem_addr=0x100; afterwards word_count=1 and mem_addr=0x104.
REQ-032 Push R sub (rd=3, rs1=1, rs2=2, fn7_5=1) -> 0x402081B3; Store (rs1=1, rs2=2, fn3=010, imm=8) -> 0x0020A423; J (rd=1, imm_uj=0x00004) -> 0x008000EF; written in order at consecutive addresses.
REQ-033 Hold mem_ack=0 and offer 3 valid tuples -> 2 accepted and in_ready=0; mem_we, mem_addr and mem_wdata stay stable; after ack pulses, 3 words land at base, base+4 and base+8.
REQ-034 Push opcode 1110011 -> err_unsupported pulses for 1 cycle; no mem_we; word_count unchanged.
REQ-035 With 2 words queued, pulse prog_start with base_addr=0x200 -> FIFO empty, mem_we=0, word_count=0; the next push writes to 0x200.
REQ-036 Assert rst while mem_we=1 -> mem_we=0 and all outputs at reset values in the same cycle; after release, the first push writes to address 0.
